// File: rtl/fade_pkg.sv
// Shared types and step arithmetic for the RGB fade engine.
package fade_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    FADING = 1'b1
  } state_t;

  // Working width for the step arithmetic; comfortably wider than any duty value.
  localparam int unsigned CALC_W = 32;

  // Move cur toward tgt by at most step counts, landing exactly on tgt rather than past it.
  function automatic logic [CALC_W-1:0] sat_step(input logic [CALC_W-1:0] cur,
                                                 input logic [CALC_W-1:0] tgt,
                                                 input logic [CALC_W-1:0] step);
    logic [CALC_W-1:0] diff;
    diff     = '0;
    sat_step = cur;
    if (cur < tgt) begin
      diff     = tgt - cur;
      sat_step = cur + ((diff < step) ? diff : step);
    end else if (cur > tgt) begin
      diff     = cur - tgt;
      sat_step = cur - ((diff < step) ? diff : step);
    end
  endfunction

endpackage

// File: rtl/fade_channel.sv
// One colour channel: latched target, current duty value and the per-step update.
module fade_channel
  import fade_pkg::*;
#(
  parameter int unsigned W       = 11,
  parameter int unsigned MAX_VAL = 1199,
  parameter int unsigned STEP    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,      // latch a new target (handshake accept)
  input  logic         step_i,      // apply one step toward the target
  input  logic [W-1:0] tgt_i,
  output logic [W-1:0] cur_o,
  output logic         load_eq_o,   // clamped incoming target equals current value
  output logic         at_tgt_o     // value after the next step equals the target
);

  localparam logic [W-1:0] MAX_W = W'(MAX_VAL);

  logic [W-1:0] tgt_q;
  logic [W-1:0] cur_q;
  logic [W-1:0] cur_d;
  logic [W-1:0] tgt_clamped;

  assign tgt_clamped = (tgt_i > MAX_W) ? MAX_W : tgt_i;
  assign cur_d       = W'(sat_step(32'(cur_q), 32'(tgt_q), 32'(STEP)));

  assign cur_o     = cur_q;
  assign load_eq_o = (tgt_clamped == cur_q);
  assign at_tgt_o  = (cur_d == tgt_q);

  // Target latches on accept; the current value only moves on step events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q <= '0;
      cur_q <= '0;
    end else begin
      if (load_i) tgt_q <= tgt_clamped;
      if (step_i) cur_q <= cur_d;
    end
  end

endmodule

// File: rtl/rgb_fade_engine.sv
// RGB fade engine: accepts target colours and ramps three PWM duty values toward them.
// Handshake: a target is taken on a rising edge where tgt_valid && tgt_ready;
// tgt_ready is high exactly while idle, and tgt_valid may drop at any time without effect.
module rgb_fade_engine
  import fade_pkg::*;
#(
  parameter  int unsigned PWM_INTERVAL    = 1200,
  parameter  int unsigned STEP            = 8,
  parameter  int unsigned FRAMES_PER_STEP = 4,
  localparam int unsigned W               = $clog2(PWM_INTERVAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  input  logic [W-1:0] tgt_r,
  input  logic [W-1:0] tgt_g,
  input  logic [W-1:0] tgt_b,
  output logic [W-1:0] r_pwm,
  output logic [W-1:0] g_pwm,
  output logic [W-1:0] b_pwm,
  output logic         busy,
  output logic         done,
  output state_t       dbg_state_o
);

  localparam int unsigned  MAX_VAL    = PWM_INTERVAL - 1;
  localparam logic [W-1:0] FRAME_LAST = W'(PWM_INTERVAL - 1);
  localparam int unsigned  DW         = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(FRAMES_PER_STEP - 1);

  state_t        state_q;
  logic          busy_q;
  logic          done_q;
  logic [W-1:0]  frame_q;
  logic [W-1:0]  frame_d;
  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  logic frame_tick;
  logic step_evt;
  logic accept;
  logic step_en;
  logic [2:0] load_eq;
  logic [2:0] at_tgt;

  assign frame_tick = (frame_q == FRAME_LAST);
  assign step_evt   = frame_tick && (div_q == DIV_LAST);
  assign tgt_ready  = (state_q == IDLE);
  assign accept     = tgt_valid && tgt_ready;
  assign step_en    = (state_q == FADING) && step_evt;

  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

  // Next frame count and step divider; a new target restarts the divider phase.
  always_comb begin
    frame_d = frame_tick ? '0 : frame_q + W'(1);
    div_d   = div_q;
    if (accept) begin
      div_d = '0;
    end else if (frame_tick) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end
  end

  // Free-running frame counter and frame divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      div_q   <= '0;
    end else begin
      frame_q <= frame_d;
      div_q   <= div_d;
    end
  end

  // Control FSM with registered busy and single-cycle done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tgt_valid) begin
            if (&load_eq) begin
              done_q <= 1'b1;
            end else begin
              state_q <= FADING;
              busy_q  <= 1'b1;
            end
          end
        end
        FADING: begin
          if (step_evt && (&at_tgt)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fade_channel #(.W(W), .MAX_VAL(MAX_VAL), .STEP(STEP)) u_red (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .step_i    (step_en),
    .tgt_i     (tgt_r),
    .cur_o     (r_pwm),
    .load_eq_o (load_eq[0]),
    .at_tgt_o  (at_tgt[0])
  );

  fade_channel #(.W(W), .MAX_VAL(MAX_VAL), .STEP(STEP)) u_green (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .step_i    (step_en),
    .tgt_i     (tgt_g),
    .cur_o     (g_pwm),
    .load_eq_o (load_eq[1]),
    .at_tgt_o  (at_tgt[1])
  );

  fade_channel #(.W(W), .MAX_VAL(MAX_VAL), .STEP(STEP)) u_blue (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .step_i    (step_en),
    .tgt_i     (tgt_b),
    .cur_o     (b_pwm),
    .load_eq_o (load_eq[2]),
    .at_tgt_o  (at_tgt[2])
  );

endmodule

// File: tb/tb_rgb_fade_engine.sv
// Testbench for rgb_fade_engine with a small interval so step events come every 32 clocks.
module tb_rgb_fade_engine;
  import fade_pkg::*;

  localparam int PI    = 16;
  localparam int ST    = 4;
  localparam int FPS   = 2;
  localparam int W     = 4;
  localparam int MAXV  = PI - 1;
  localparam int FRAME = PI;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tgt_valid = 1'b0;
  logic [W-1:0] tgt_r = '0;
  logic [W-1:0] tgt_g = '0;
  logic [W-1:0] tgt_b = '0;
  logic         tgt_ready;
  logic [W-1:0] r_pwm, g_pwm, b_pwm;
  logic         busy, done;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int m_cur[3];
  int prev_done = 0;
  bit prev_hold = 1'b0;

  typedef struct {
    int tr, tg, tb;
    bit hold;
    int steps;
    int fr, fg, fb;
  } vec_t;
  vec_t tbl[6];

  rgb_fade_engine #(.PWM_INTERVAL(PI), .STEP(ST), .FRAMES_PER_STEP(FPS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tgt_valid   (tgt_valid),
    .tgt_ready   (tgt_ready),
    .tgt_r       (tgt_r),
    .tgt_g       (tgt_g),
    .tgt_b       (tgt_b),
    .r_pwm       (r_pwm),
    .g_pwm       (g_pwm),
    .b_pwm       (b_pwm),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // Clock and rising-edge counter since reset release.
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: a channel needs ceil(|t-s|/STEP) step events and after k of
  // them has moved min(k*STEP, |t-s|) toward its target.
  function automatic int clampv(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic int steps_needed(input int s, input int t);
    int d;
    d = (t > s) ? t - s : s - t;
    return (d + ST - 1) / ST;
  endfunction

  function automatic int val_after(input int s, input int t, input int k);
    int d, mv;
    d  = (t > s) ? t - s : s - t;
    mv = (k * ST < d) ? k * ST : d;
    return (t >= s) ? s + mv : s - mv;
  endfunction

  // Apply one target and check every cycle until completion. Step events land on
  // every FPS-th frame boundary after the accept edge; done and busy follow them.
  task automatic run_fade(input string name, input int tr, input int tg, input int tb,
                          input bit hold, input int exp_steps,
                          input int fr, input int fg, input int fb);
    int t[3], s[3], last[3], e[3];
    int a, n, done_at, k, tries, seen;
    bit fading_exp;
    t = '{clampv(tr), clampv(tg), clampv(tb)};
    s = m_cur;
    tries = 0;
    while (!tgt_ready && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    chk({name, " ready_before_accept"}, int'(tgt_ready), 1);
    tgt_r = W'(tr);
    tgt_g = W'(tg);
    tgt_b = W'(tb);
    tgt_valid = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    if (prev_hold) chk({name, " held_valid_accept_edge"}, a, prev_done + 1);
    tgt_valid = hold;
    if (hold) begin
      tgt_r = '0;
      tgt_g = '0;
      tgt_b = '0;
    end
    n = 0;
    for (int c = 0; c < 3; c++) if (steps_needed(s[c], t[c]) > n) n = steps_needed(s[c], t[c]);
    done_at = (n == 0) ? a : (a / FRAME + FPS * n) * FRAME;
    last = s;
    seen = 0;
    do begin
      @(negedge clk);
      k = ((cyc / FRAME) - (a / FRAME)) / FPS;
      if (k > n) k = n;
      if (k < 0) k = 0;
      for (int c = 0; c < 3; c++) e[c] = val_after(s[c], t[c], k);
      fading_exp = (n > 0) && (cyc < done_at);
      chk({name, " r_pwm"}, int'(r_pwm), e[0]);
      chk({name, " g_pwm"}, int'(g_pwm), e[1]);
      chk({name, " b_pwm"}, int'(b_pwm), e[2]);
      chk({name, " busy"}, int'(busy), int'(fading_exp));
      chk({name, " tgt_ready"}, int'(tgt_ready), int'(!fading_exp));
      chk({name, " done"}, int'(done), int'(cyc == done_at));
      if (int'(r_pwm) != last[0] || int'(g_pwm) != last[1] || int'(b_pwm) != last[2]) seen++;
      last = '{int'(r_pwm), int'(g_pwm), int'(b_pwm)};
      if (!hold) begin
        if (cyc < done_at) begin
          tgt_valid = 1'($urandom_range(0, 1));
          tgt_r = W'($urandom_range(0, MAXV));
          tgt_g = W'($urandom_range(0, MAXV));
          tgt_b = W'($urandom_range(0, MAXV));
        end else begin
          tgt_valid = 1'b0;
        end
      end
    end while (cyc < done_at);
    chk({name, " step_count"}, seen, exp_steps);
    chk({name, " final_r"}, int'(r_pwm), fr);
    chk({name, " final_g"}, int'(g_pwm), fg);
    chk({name, " final_b"}, int'(b_pwm), fb);
    m_cur = t;
    prev_done = done_at;
    prev_hold = hold;
    if (!hold) begin
      @(negedge clk);
      chk({name, " done_one_cycle"}, int'(done), 0);
      chk({name, " idle_busy"}, int'(busy), 0);
      chk({name, " idle_ready"}, int'(tgt_ready), 1);
    end
  endtask

  initial begin
    int a, step2, tries, tr, tg, tb, n;

    tbl[0] = '{15, 0, 8, 1'b0, 4, 15, 0, 8};  // upward fade from black
    tbl[1] = '{1, 3, 8, 1'b0, 4, 1, 3, 8};    // downward, non-multiple distances
    tbl[2] = '{1, 3, 8, 1'b0, 0, 1, 3, 8};    // target equals current: immediate done
    tbl[3] = '{15, 0, 0, 1'b1, 4, 15, 0, 0};  // valid held with (0,0,0) throughout
    tbl[4] = '{0, 0, 0, 1'b0, 4, 0, 0, 0};    // the held target, taken on the done cycle
    tbl[5] = '{15, 0, 0, 1'b0, 4, 15, 0, 0};  // full-scale red (all-ones input is MAX_VAL here)

    m_cur = '{0, 0, 0};

    // Reset values, during and after reset.
    repeat (3) @(negedge clk);
    chk("in_reset r_pwm", int'(r_pwm), 0);
    chk("in_reset busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset r_pwm", int'(r_pwm), 0);
    chk("reset g_pwm", int'(g_pwm), 0);
    chk("reset b_pwm", int'(b_pwm), 0);
    chk("reset tgt_ready", int'(tgt_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset state", int'(dbg_state), int'(IDLE));

    for (int i = 0; i < 6; i++) begin
      run_fade($sformatf("vec%0d", i), tbl[i].tr, tbl[i].tg, tbl[i].tb, tbl[i].hold,
               tbl[i].steps, tbl[i].fr, tbl[i].fg, tbl[i].fb);
    end

    // Reset in the middle of a fade from (15,0,0) toward (0,15,15).
    tries = 0;
    while (!tgt_ready && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    tgt_r = 4'd0;
    tgt_g = 4'd15;
    tgt_b = 4'd15;
    tgt_valid = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    tgt_valid = 1'b0;
    step2 = (a / FRAME + 2 * FPS) * FRAME;
    tries = 0;
    while (cyc < step2 && tries < 500) begin
      @(negedge clk);
      tries++;
    end
    chk("midreset two_steps_r", int'(r_pwm), 7);
    chk("midreset two_steps_g", int'(g_pwm), 8);
    chk("midreset two_steps_b", int'(b_pwm), 8);
    chk("midreset busy_before", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset async_r", int'(r_pwm), 0);
    chk("midreset async_g", int'(g_pwm), 0);
    chk("midreset async_b", int'(b_pwm), 0);
    chk("midreset async_busy", int'(busy), 0);
    chk("midreset async_ready", int'(tgt_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset ready", int'(tgt_ready), 1);
    chk("after_reset state", int'(dbg_state), int'(IDLE));
    chk("after_reset r_pwm", int'(r_pwm), 0);
    m_cur = '{0, 0, 0};
    prev_hold = 1'b0;

    // Random targets checked against the model.
    for (int i = 0; i < 8; i++) begin
      tr = $urandom_range(0, MAXV);
      tg = $urandom_range(0, MAXV);
      tb = $urandom_range(0, MAXV);
      if (i == 3) begin
        tr = m_cur[0];
        tg = m_cur[1];
        tb = m_cur[2];
      end
      n = 0;
      if (steps_needed(m_cur[0], tr) > n) n = steps_needed(m_cur[0], tr);
      if (steps_needed(m_cur[1], tg) > n) n = steps_needed(m_cur[1], tg);
      if (steps_needed(m_cur[2], tb) > n) n = steps_needed(m_cur[2], tb);
      run_fade($sformatf("rand%0d", i), tr, tg, tb, 1'b0, n, tr, tg, tb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
